// File: rtl/xadac_axi_rd_arb.sv
// xadac_axi_rd_arb
//   Shares one AXI read port (AR + R) between NumReq vector-load requesters.
//   AR requests are arbitrated round-robin into a single registered output
//   slot and tagged with the requester index in the upper ID bits. R beats
//   are routed back combinationally by that index. Per-requester counters
//   cap each requester at MaxOutstanding reads in flight.
//
// Ports
//   clk, rst               clock, asynchronous active-high reset
//   s_ar_id/addr/valid     requester AR channels (packed, requester 0 in LSBs)
//   s_ar_ready             requester AR readies (at most one set)
//   s_r_id/data/valid      R channel fanned out to every requester
//   s_r_ready              requester R readies
//   m_ar_id/addr/valid     downstream AR, m_ar_id = {index, id}
//   m_ar_ready             downstream AR ready
//   m_r_id/data/valid      downstream R channel
//   m_r_ready              downstream R ready
//   idle                   no reads in flight and AR slot empty
//   err                    sticky: R beat with an index >= NumReq was dropped
//
// Optional build macro XADAC_AXI_RD_ARB_PERF_EN adds:
//   perf_stall_cycles      cycles with m_ar_valid && !m_ar_ready (wrapping)
//   perf_grants            per-requester 32-bit grant counts (wrapping)
module xadac_axi_rd_arb #(
    parameter int NumReq         = 2,
    parameter int IdWidth        = 4,
    parameter int AddrWidth      = 32,
    parameter int DataWidth      = 128,
    parameter int MaxOutstanding = 4,
    localparam int IdxW          = $clog2(NumReq),
    localparam int CntW          = $clog2(MaxOutstanding + 1),
    localparam int MIdW          = IdWidth + IdxW
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NumReq*IdWidth-1:0]     s_ar_id,
    input  logic [NumReq*AddrWidth-1:0]   s_ar_addr,
    input  logic [NumReq-1:0]             s_ar_valid,
    output logic [NumReq-1:0]             s_ar_ready,
    output logic [NumReq*IdWidth-1:0]     s_r_id,
    output logic [NumReq*DataWidth-1:0]   s_r_data,
    output logic [NumReq-1:0]             s_r_valid,
    input  logic [NumReq-1:0]             s_r_ready,
    output logic [MIdW-1:0]               m_ar_id,
    output logic [AddrWidth-1:0]          m_ar_addr,
    output logic                          m_ar_valid,
    input  logic                          m_ar_ready,
    input  logic [MIdW-1:0]               m_r_id,
    input  logic [DataWidth-1:0]          m_r_data,
    input  logic                          m_r_valid,
    output logic                          m_r_ready,
    output logic                          idle,
    output logic                          err
`ifdef XADAC_AXI_RD_ARB_PERF_EN
    ,
    output logic [31:0]                   perf_stall_cycles,
    output logic [NumReq*32-1:0]          perf_grants
`endif
);

    logic [IdxW-1:0]      ptr;
    logic [IdxW-1:0]      gnt_idx;
    logic [IdxW:0]        cand;
    logic                 any_elig;
    logic                 ld;
    logic [NumReq-1:0]    elig;
    logic [NumReq-1:0]    grant;
    logic [NumReq-1:0]    r_hs;
    logic [CntW-1:0]      cnt [NumReq];
    logic [IdWidth-1:0]   sel_id;
    logic [AddrWidth-1:0] sel_addr;
    logic [IdxW-1:0]      r_idx;
    logic                 r_idx_ok;
    logic                 r_sel_ready;

    // The output slot can take a new entry when empty or being drained now.
    assign ld = !m_ar_valid || m_ar_ready;

    always_comb begin
        for (int i = 0; i < NumReq; i++) begin
            elig[i] = s_ar_valid[i] && (cnt[i] < CntW'(MaxOutstanding));
        end
    end

    // Round-robin: first eligible index at or after ptr, wrapping.
    always_comb begin
        any_elig = 1'b0;
        gnt_idx  = '0;
        cand     = '0;
        for (int k = 0; k < NumReq; k++) begin
            cand = {1'b0, ptr} + (IdxW+1)'(k);
            if (cand >= (IdxW+1)'(NumReq)) begin
                cand = cand - (IdxW+1)'(NumReq);
            end
            if (!any_elig && elig[cand[IdxW-1:0]]) begin
                any_elig = 1'b1;
                gnt_idx  = cand[IdxW-1:0];
            end
        end
    end

    always_comb begin
        grant    = '0;
        sel_id   = '0;
        sel_addr = '0;
        for (int k = 0; k < NumReq; k++) begin
            if (gnt_idx == IdxW'(k)) begin
                grant[k] = any_elig;
                sel_id   = s_ar_id[k*IdWidth +: IdWidth];
                sel_addr = s_ar_addr[k*AddrWidth +: AddrWidth];
            end
        end
    end

    // Grant implies valid, so s_ar_ready doubles as the AR handshake.
    assign s_ar_ready = ld ? grant : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ar_valid <= 1'b0;
            m_ar_id    <= '0;
            m_ar_addr  <= '0;
            ptr        <= '0;
        end else if (ld) begin
            if (any_elig) begin
                m_ar_valid <= 1'b1;
                m_ar_id    <= {gnt_idx, sel_id};
                m_ar_addr  <= sel_addr;
                ptr        <= (gnt_idx == IdxW'(NumReq-1)) ? '0 : gnt_idx + IdxW'(1);
            end else begin
                m_ar_valid <= 1'b0;
            end
        end
    end

    // R routing by the index tag in the upper ID bits.
    assign r_idx = m_r_id[MIdW-1 -: IdxW];

    generate
        if ((1 << IdxW) == NumReq) begin : g_idx_full
            assign r_idx_ok = 1'b1;
        end else begin : g_idx_part
            assign r_idx_ok = (r_idx < IdxW'(NumReq));
        end
    endgenerate

    always_comb begin
        s_r_valid   = '0;
        r_sel_ready = 1'b0;
        for (int k = 0; k < NumReq; k++) begin
            if (r_idx == IdxW'(k)) begin
                s_r_valid[k] = m_r_valid;
                r_sel_ready  = s_r_ready[k];
            end
        end
    end

    // An unroutable beat is accepted and dropped so the bus never locks up.
    assign m_r_ready = r_idx_ok ? r_sel_ready : 1'b1;
    assign s_r_id    = {NumReq{m_r_id[IdWidth-1:0]}};
    assign s_r_data  = {NumReq{m_r_data}};
    assign r_hs      = s_r_valid & s_r_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (m_r_valid && !r_idx_ok) begin
            err <= 1'b1;
        end
    end

    // A return at zero is a requester protocol error; hold at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NumReq; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NumReq; i++) begin
                if (s_ar_ready[i] && !r_hs[i]) begin
                    cnt[i] <= cnt[i] + CntW'(1);
                end else if (!s_ar_ready[i] && r_hs[i] && (cnt[i] != '0)) begin
                    cnt[i] <= cnt[i] - CntW'(1);
                end
            end
        end
    end

    always_comb begin
        idle = !m_ar_valid;
        for (int i = 0; i < NumReq; i++) begin
            if (cnt[i] != '0) begin
                idle = 1'b0;
            end
        end
    end

`ifdef XADAC_AXI_RD_ARB_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cycles <= '0;
            perf_grants       <= '0;
        end else begin
            if (m_ar_valid && !m_ar_ready) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
            for (int i = 0; i < NumReq; i++) begin
                if (s_ar_ready[i]) begin
                    perf_grants[i*32 +: 32] <= perf_grants[i*32 +: 32] + 32'd1;
                end
            end
        end
    end
`endif

endmodule

// File: doc/xadac_axi_rd_arb.md
Name: xadac_axi_rd_arb

Overview:
- Shares one AXI read port (AR + R channels) between NumReq xadac vector-load requesters.
- AR requests are arbitrated round-robin, tagged with the requester index in the upper ID bits, and sent through a registered output stage.
- R beats are routed back to the owning requester by that index.
- Per-requester outstanding counters throttle each requester to MaxOutstanding in-flight reads.

Parameters:
- NumReq, 2, number of requesters (>=2).
- IdWidth, 4, requester-side AXI ID width.
- AddrWidth, 32, address width.
- DataWidth, 128, R data width (vector data width).
- MaxOutstanding, 4, maximum in-flight reads per requester (>=1).
- Derived: IdxW = $clog2(NumReq); CntW = $clog2(MaxOutstanding+1); MIdW = IdWidth+IdxW.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- s_ar_id  in  NumReq*IdWidth  requester AR IDs
- s_ar_addr  in  NumReq*AddrWidth  requester AR addresses
- s_ar_valid  in  NumReq  requester AR valids
- s_ar_ready  out  NumReq  requester AR readies
- s_r_id  out  NumReq*IdWidth  R ID to each requester
- s_r_data  out  NumReq*DataWidth  R data to each requester
- s_r_valid  out  NumReq  R valid per requester
- s_r_ready  in  NumReq  R ready per requester
- m_ar_id  out  MIdW  {index, id}
- m_ar_addr  out  AddrWidth  downstream AR address
- m_ar_valid  out  1  downstream AR valid
- m_ar_ready  in  1  downstream AR ready
- m_r_id  in  MIdW  downstream R ID
- m_r_data  in  DataWidth  downstream R data
- m_r_valid  in  1  downstream R valid
- m_r_ready  out  1  downstream R ready
- idle  out  1  all counters zero and m_ar_valid low
- err  out  1  sticky: R beat seen with index >= NumReq

Behaviour:
- Reset (async, rst=1):
  - m_ar_valid/id/addr = 0; RR pointer = 0; all counters = 0; err = 0; idle = 1.
- AR output register (one entry):
  - Load enable: ld = !m_ar_valid || m_ar_ready.
  - Eligible requester i: s_ar_valid[i] && cnt[i] < MaxOutstanding.
  - When ld and any requester is eligible, grant the first eligible index searching from ptr upward with wrap.
  - s_ar_ready[i] = ld && grant[i]. This is combinational, with at most one bit set.
  - On grant: register loads {i, s_ar_id[i]} and s_ar_addr[i]; m_ar_valid=1; ptr <= (i+1) mod NumReq.
  - When ld and nothing is eligible: m_ar_valid <= 0.
  - Registered fields hold stable while m_ar_valid && !m_ar_ready.
  - Latency: requester handshake to m_ar_valid is 1 cycle. Back-to-back grants are supported at full throughput.
- R routing (combinational, zero latency):
  - idx = m_r_id[MIdW-1 -: IdxW].
  - For idx < NumReq: s_r_valid[idx] = m_r_valid; all other s_r_valid = 0; m_r_ready = s_r_ready[idx].
  - s_r_id[k] = m_r_id[IdWidth-1:0] and s_r_data[k] = m_r_data for all k.
  - For idx >= NumReq: m_r_ready = 1 (beat dropped), and err <= 1 on that handshake.
- Counters:
  - cnt[i] increments on s_ar handshake for i and decrements on s_r handshake for i. Both in the same cycle leaves it unchanged.
  - A decrement at 0 is a protocol violation. The counter saturates at 0 and err is not set.
- RR pointer moves only on a grant.
- A full requester (cnt==MaxOutstanding) is skipped, not blocking others. Its ready stays 0 even when ld=1.
- A requester whose valid drops while not granted is legal for this block. The requester must follow AXI.
- idle = (all cnt==0) && !m_ar_valid, combinational from state.

Optional Feature:
- XADAC_AXI_RD_ARB_PERF_EN defined:
  - Adds output perf_stall_cycles (32 bits): increments each cycle m_ar_valid && !m_ar_ready, wraps at 2^32, reset 0.
  - Adds output perf_grants (NumReq*32): per-requester grant counts, wrapping, reset 0.
- Not defined: these ports and registers are absent, and behaviour is otherwise identical.

Test Plan:
- Single request: req0 ar addr=0x1000 id=3, m_ar_ready=1 -> next cycle m_ar_id={0,3}, addr=0x1000; cnt0=1; R with id={0,3}, data=0xA5.. -> s_r_valid[0]=1, s_r_id[0]=3; cnt0 back to 0; idle=1.
- Fairness: both requesters valid continuously, ready=1 -> grants alternate 0,1,0,1; ptr wraps correctly.
- Throttle (MaxOutstanding=4): req0 issues 4 with no R returned -> 5th request gets s_ar_ready[0]=0 while req1 is still granted. One R to req0 -> req0 is granted the following cycle.
- Downstream backpressure: m_ar_ready=0 for 3 cycles with valid entry -> m_ar_id/addr stable, no s_ar_ready asserted. Ready=1 -> the next grant loads in the same cycle.
- Simultaneous events: grant to req1 and R to req1 in the same cycle with cnt1=2 -> cnt1 stays 2.
- Bad index (NumReq=3, IdxW=2): R with idx=3 -> m_r_ready=1, no s_r_valid, err=1 and sticky until rst. Async rst mid-transfer clears all state immediately.
